// File: rtl/prisc_pkg.sv
// Shared definitions for the prisc core: fetch FSM encoding and PC constants.
package prisc_pkg;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int unsigned PC_STEP  = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;

    // Buffer entry layout: {pc, instruction word}
    localparam int unsigned ENTRY_W = 64;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer holding {pc, instr} pairs; clear wins over push/pop.
module fetch_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [63:0] push_data_i,
    input  logic        pop_i,
    output logic [63:0] head_o,
    output logic [1:0]  count_o
);

    logic [63:0] mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        do_push;
    logic        do_pop;

    assign do_push = push_i && ((count_q != 2'd2) || pop_i);
    assign do_pop  = pop_i && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the PC register's next value, issues one memory
// request at a time and buffers returned words for decode.
module instr_fetch #(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned PC_STEP   = prisc_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] next_pc,
    input  logic        br_take,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        dec_ready
);
    import prisc_pkg::*;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] req_addr_q;
    logic [31:0] req_addr_d;
    logic [63:0] head;
    logic [1:0]  count;
    logic        in_flight;
    logic        has_room;
    logic        push;
    logic        pop;

    assign in_flight = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign has_room  = 32'(count) < BUF_DEPTH;

    assign imem_req  = in_flight;
    assign imem_addr = in_flight ? req_addr_q : 32'd0;

    assign instr_valid = (count != 2'd0);
    assign instr       = instr_valid ? head[31:0] : 32'd0;
    assign instr_pc    = instr_valid ? head[63:32] : 32'd0;

    // A redirect flushes the buffer, so it also suppresses any push or pop.
    assign push = (state_q == S_REQ) && imem_ack && !br_take;
    assign pop  = instr_valid && dec_ready && !br_take;

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        next_pc    = pc_in;
        case (state_q)
            S_BOOT: begin
                next_pc = pc_in + STEP;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (has_room && !br_take) begin
                    req_addr_d = pc_in;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                    next_pc = pc_in + STEP;
                end else if (br_take) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_BOOT;
        endcase
        if (br_take) begin
            next_pc = br_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            req_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_fifo u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (br_take),
        .push_i      (push),
        .push_data_i ({req_addr_q, imem_rdata}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a bench-side PC register and a simple memory.
module tb_instr_fetch;
    import prisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        br_take;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        dec_ready;
    logic        auto_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int req_seen;

    always #5 clk = ~clk;

    // PC register with no enable, as the fetch unit expects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= next_pc;
    end

    instr_fetch #(
        .BUF_DEPTH (2),
        .PC_STEP   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_q),
        .next_pc     (next_pc),
        .br_take     (br_take),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .dec_ready   (dec_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic mem_drive();
        imem_ack   = auto_ack && imem_req;
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'd0;
    endtask

    // Advance to the middle of the next cycle and refresh the memory model.
    task automatic next_cycle();
        @(negedge clk);
        mem_drive();
        #1;
    endtask

    initial begin
        rst = 1'b1; br_take = 1'b0; br_target = '0; imem_ack = 1'b0; imem_rdata = '0;
        dec_ready = 1'b0; auto_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_imem_req", 32'(imem_req), 0);
        check_eq("rst_imem_addr", imem_addr, 32'h0);
        check_eq("rst_instr_valid", 32'(instr_valid), 0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("rst_next_pc", next_pc, 32'h0000_0000);

        // Sequential fetch, single-cycle memory, decode always ready
        rst = 1'b0; auto_ack = 1'b1; dec_ready = 1'b1; #1;
        check_eq("boot_next_pc", next_pc, 32'h0);
        next_cycle();
        check_eq("idle_no_req", 32'(imem_req), 0);
        check_eq("idle_hold_pc", next_pc, 32'h0);
        next_cycle();
        check_eq("req0_req", 32'(imem_req), 1);
        check_eq("req0_addr", imem_addr, 32'h0);
        check_eq("req0_next_pc", next_pc, 32'h4);
        next_cycle();
        check_eq("out0_valid", 32'(instr_valid), 1);
        check_eq("out0_pc", instr_pc, 32'h0);
        check_eq("out0_instr", instr, 32'hA500_0000);
        next_cycle();
        check_eq("req4_addr", imem_addr, 32'h4);
        check_eq("req4_next_pc", next_pc, 32'h8);

        // Decode stalls: buffer fills with pc 4 and 8, then fetch stops
        dec_ready = 1'b0;
        req_seen  = 0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if (i >= 2 && imem_req) req_seen++;
        end
        check_eq("stall_no_req", 32'(req_seen), 0);
        check_eq("stall_imem_req", 32'(imem_req), 0);
        check_eq("stall_next_pc", next_pc, pc_q);
        check_eq("stall_pc_val", pc_q, 32'hC);
        check_eq("stall_head_pc", instr_pc, 32'h4);
        dec_ready = 1'b1;
        auto_ack  = 1'b0;
        next_cycle();
        check_eq("stall_second_pc", instr_pc, 32'h8);
        check_eq("stall_second_instr", instr, 32'hA500_0008);

        // Redirect while a request is outstanding, ack three cycles later
        next_cycle();
        check_eq("br_req_addr", imem_addr, 32'hC);
        br_take = 1'b1; br_target = 32'h100; #1;
        check_eq("br_next_pc", next_pc, 32'h100);
        next_cycle();
        br_take = 1'b0; #1;
        check_eq("drain_req", 32'(imem_req), 1);
        check_eq("drain_addr", imem_addr, 32'hC);
        next_cycle();
        next_cycle();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        check_eq("drain_ack_next_pc", next_pc, 32'h100);
        next_cycle();
        check_eq("drain_discard", 32'(instr_valid), 0);
        check_eq("drain_idle_req", 32'(imem_req), 0);
        next_cycle();
        check_eq("post_br_addr", imem_addr, 32'h100);
        auto_ack = 1'b1; mem_drive(); #1;
        dec_ready = 1'b0;

        // Redirect coincident with ack and a decode handshake
        next_cycle();
        check_eq("coin_head_pc", instr_pc, 32'h100);
        next_cycle();
        check_eq("coin_req_addr", imem_addr, 32'h104);
        check_eq("coin_ack", 32'(imem_ack), 1);
        dec_ready = 1'b1; br_take = 1'b1; br_target = 32'h200; #1;
        check_eq("coin_next_pc", next_pc, 32'h200);
        next_cycle();
        br_take = 1'b0; auto_ack = 1'b0; #1;
        check_eq("coin_empty", 32'(instr_valid), 0);
        check_eq("coin_hold_pc", next_pc, 32'h200);

        // Reset pulse in the middle of a request, with stray acks afterwards
        next_cycle();
        check_eq("mid_req_before_rst", 32'(imem_req), 1);
        rst = 1'b1; #1;
        check_eq("mid_rst_req_drop", 32'(imem_req), 0);
        check_eq("mid_rst_addr", imem_addr, 32'h0);
        next_cycle();
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678; #1;
        check_eq("rst2_boot_next_pc", next_pc, 32'h0);
        next_cycle();
        imem_ack = 1'b1; #1;
        check_eq("rst2_stray_idle_pc", next_pc, 32'h0);
        check_eq("rst2_stray_valid", 32'(instr_valid), 0);
        auto_ack = 1'b1;
        next_cycle();
        check_eq("rst2_first_addr", imem_addr, 32'h0);
        check_eq("rst2_first_req", 32'(imem_req), 1);

        // PC wrap at the top of the address space
        next_cycle();
        check_eq("rst2_first_instr_pc", instr_pc, 32'h0);
        br_take = 1'b1; br_target = 32'hFFFF_FFFC; #1;
        next_cycle();
        br_take = 1'b0; #1;
        check_eq("wrap_pc_in", pc_q, 32'hFFFF_FFFC);
        next_cycle();
        check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check_eq("wrap_next_pc", next_pc, 32'h0000_0000);
        next_cycle();
        check_eq("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        check_eq("wrap_instr", instr, 32'h5AFF_FFFC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
